eeprom_avs_arbiter: RTL and testbench
=====================================

Name: eeprom_avs_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 256x32 EEPROM shadow-RAM Avalon-MM slave.
- Requester 0 is the host/NIOS bridge. Requester 1 is the I2C EEPROM load/store engine.
- Each requester issues a single-word read or write. The block serialises the requests onto the one slave port, holds address and data stable for the slave's access window, captures read data, and returns a one-cycle ack.
- A timeout flags a slave that keeps waitrequest asserted.

Parameters:
- HOLD_CYCLES, 10: cycles the address, data and command stay held after the issue cycle before completion is checked (range 1..255).
- TIMEOUT_CYCLES, 64: further cycles allowed with m_waitrequest high before the transaction is aborted with an error (range 1..255).

Ports:
- clk_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- s0_req  in  1  requester 0 request; level, held until s0_ack
- s0_we  in  1  1 = write, 0 = read; stable while s0_req is high
- s0_addr  in  8  word address
- s0_wdata  in  32  write data
- s0_rdata  out  32  last read data completed for port 0
- s0_ack  out  1  one-cycle completion pulse
- s0_err  out  1  valid with s0_ack; 1 = timeout
- s1_req, s1_we, s1_addr, s1_wdata, s1_rdata, s1_ack, s1_err: same as port 0, for requester 1
- m_addr  out  8  slave address
- m_wdata  out  32  slave write data
- m_write  out  1  slave write enable
- m_read  out  1  slave read enable
- m_readdata  in  32  slave read data
- m_waitrequest  in  1  slave stall
- grant  out  2  one-hot owner of the current transaction; 00 when idle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE; all outputs = 0 (rdata registers 0, grant 00).
  - last_grant = 1, so port 0 wins the first contention.
  - Counters = 0. A transaction in flight is dropped with no ack.
- FSM states: IDLE, ISSUE, HOLD, WAIT, DONE.
- IDLE:
  - Sample s0_req and s1_req at each edge.
  - Neither high: stay in IDLE.
  - One high: grant that port.
  - Both high: grant the port other than last_grant.
  - On grant: latch the owner's we, addr and wdata into m_addr/m_wdata; set grant one-hot; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - m_write = we or m_read = ~we; never both high.
  - Go to HOLD; counter = 0.
- HOLD:
  - m_write = m_read = 0; m_addr and m_wdata held.
  - Counter increments each cycle. When counter = HOLD_CYCLES-1:
    - m_waitrequest = 0: complete.
    - m_waitrequest = 1: go to WAIT; counter = 0.
- WAIT:
  - m_waitrequest = 0: complete.
  - Otherwise counter increments. When counter = TIMEOUT_CYCLES-1 with waitrequest still high: abort.
- Complete: on a read, the owner's rdata <= m_readdata sampled that same edge; on a write, rdata is unchanged. Go to DONE with err = 0.
- Abort: rdata unchanged; go to DONE with err = 1.
- DONE (exactly 1 cycle):
  - Owner's ack = 1 and err valid; the other port's ack = 0.
  - grant stays on the owner for this cycle.
  - Next edge: grant = 00, go to IDLE.
- Requester rule: drop req on the edge that ends DONE. A req still high in IDLE is treated as a new request. It still obeys round-robin, so a port holding req cannot starve the other.
- Latency, no waitrequest: req sampled at edge E. ISSUE occupies cycle E+1, HOLD occupies E+2 .. E+1+HOLD_CYCLES, and ack is high in cycle E+2+HOLD_CYCLES. Default: 12 cycles.
- Arbitration and other-port requests: a request arriving mid-transaction waits in its req level; it is never preempted.
- Widths:
  - Address passes through unchanged (8 bits); no wrap logic.
  - Counters are 8 bits; parameter values outside 1..255 are illegal.

Test Plan:
- Single read: s0 read, addr 0x05, slave returns 0xDEADBEEF, waitrequest low → m_read high exactly 1 cycle, s0_ack exactly 12 cycles after sampling, s0_rdata = 0xDEADBEEF, s0_err = 0.
- Single write: s1 write, addr 0xFF, wdata 0x12345678 → m_write 1 cycle, m_addr/m_wdata stable for 11 cycles, s1_ack with s1_err = 0, s1_rdata unchanged.
- Contention: s0 and s1 requests both raised in the same cycle after reset → port 0 served first, port 1 second. Repeat with both held continuously → grants alternate 01, 10, 01, 10 …
- Stall: waitrequest held high 5 cycles past the hold window → ack delayed by 5 cycles, err = 0, data captured on the first low cycle.
- Timeout: waitrequest stuck high → ack at HOLD_CYCLES + TIMEOUT_CYCLES + 2 cycles after sampling, err = 1, rdata unchanged. The next request still completes normally.
- Reset mid-HOLD: assert reset_n low → all outputs 0 immediately, no ack. After release, a new s1 request is granted normally.

Source files
------------

// File: rtl/eeprom_avs_arbiter.sv
// Round-robin two-port sequencer for the 256x32 EEPROM shadow-RAM Avalon-MM slave.
// Each single-word access is held for a fixed window, then waits (bounded) on waitrequest.
module eeprom_avs_arbiter #(
   parameter int unsigned HOLD_CYCLES    = 10,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk_50,
   input  logic        reset_n,
   input  logic        s0_req,
   input  logic        s0_we,
   input  logic [7:0]  s0_addr,
   input  logic [31:0] s0_wdata,
   output logic [31:0] s0_rdata,
   output logic        s0_ack,
   output logic        s0_err,
   input  logic        s1_req,
   input  logic        s1_we,
   input  logic [7:0]  s1_addr,
   input  logic [31:0] s1_wdata,
   output logic [31:0] s1_rdata,
   output logic        s1_ack,
   output logic        s1_err,
   output logic [7:0]  m_addr,
   output logic [31:0] m_wdata,
   output logic        m_write,
   output logic        m_read,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest,
   output logic [1:0]  grant,
   output logic        busy
);

   typedef enum logic [2:0] {StIdle, StIssue, StHold, StWait, StDone} state_e;

   localparam logic [7:0] HoldLast    = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   state_e     r_state;
   logic [7:0] r_cnt;
   logic       r_last_grant;  // 1 = port 1 was served most recently
   logic       r_we;
   logic       w_pick1;
   logic       w_owner_we;
   logic       w_finish;
   logic       w_timeout;

   always_comb begin
      w_pick1    = (s0_req && s1_req) ? ~r_last_grant : s1_req;
      w_owner_we = w_pick1 ? s1_we : s0_we;
      w_finish   = 1'b0;
      w_timeout  = 1'b0;
      if (r_state == StHold) begin
         w_finish = (r_cnt == HoldLast) && !m_waitrequest;
      end else if (r_state == StWait) begin
         w_finish  = !m_waitrequest || (r_cnt == TimeoutLast);
         w_timeout = m_waitrequest;
      end
   end

   assign busy = (r_state != StIdle);

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_cnt        <= 8'd0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         grant        <= 2'b00;
         m_addr       <= 8'd0;
         m_wdata      <= 32'd0;
         m_write      <= 1'b0;
         m_read       <= 1'b0;
         s0_rdata     <= 32'd0;
         s1_rdata     <= 32'd0;
         s0_ack       <= 1'b0;
         s1_ack       <= 1'b0;
         s0_err       <= 1'b0;
         s1_err       <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (s0_req || s1_req) begin
                  grant        <= w_pick1 ? 2'b10 : 2'b01;
                  r_last_grant <= w_pick1;
                  r_we         <= w_owner_we;
                  m_write      <= w_owner_we;
                  m_read       <= ~w_owner_we;
                  m_addr       <= w_pick1 ? s1_addr : s0_addr;
                  m_wdata      <= w_pick1 ? s1_wdata : s0_wdata;
                  r_state      <= StIssue;
               end
            end
            StIssue: begin
               m_write <= 1'b0;
               m_read  <= 1'b0;
               r_cnt   <= 8'd0;
               r_state <= StHold;
            end
            StHold: begin
               if (r_cnt == HoldLast) begin
                  r_cnt <= 8'd0;
                  if (m_waitrequest) r_state <= StWait;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            StWait: begin
               if (!w_finish) r_cnt <= r_cnt + 8'd1;
            end
            StDone: begin
               s0_ack  <= 1'b0;
               s1_ack  <= 1'b0;
               s0_err  <= 1'b0;
               s1_err  <= 1'b0;
               grant   <= 2'b00;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase

         // Completion or abort overrides the per-state next-state above.
         if (w_finish) begin
            r_state <= StDone;
            s0_ack  <= grant[0];
            s1_ack  <= grant[1];
            s0_err  <= grant[0] & w_timeout;
            s1_err  <= grant[1] & w_timeout;
            if (!r_we && !w_timeout) begin
               if (grant[1]) s1_rdata <= m_readdata;
               else          s0_rdata <= m_readdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_eeprom_avs_arbiter.sv
// Bench for eeprom_avs_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_eeprom_avs_arbiter;

   localparam int H = 10;
   localparam int T = 64;

   logic        clk_50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        s0_req = 1'b0, s0_we = 1'b0, s1_req = 1'b0, s1_we = 1'b0;
   logic [7:0]  s0_addr = 8'd0, s1_addr = 8'd0;
   logic [31:0] s0_wdata = 32'd0, s1_wdata = 32'd0;
   logic [31:0] s0_rdata, s1_rdata;
   logic        s0_ack, s0_err, s1_ack, s1_err;
   logic [7:0]  m_addr;
   logic [31:0] m_wdata;
   logic        m_write, m_read;
   logic [31:0] m_readdata = 32'd0;
   logic        m_waitrequest = 1'b0;
   logic [1:0]  grant;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #10 clk_50 = ~clk_50;

   eeprom_avs_arbiter #(
      .HOLD_CYCLES   (H),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk_50       (clk_50),
      .reset_n      (reset_n),
      .s0_req       (s0_req),
      .s0_we        (s0_we),
      .s0_addr      (s0_addr),
      .s0_wdata     (s0_wdata),
      .s0_rdata     (s0_rdata),
      .s0_ack       (s0_ack),
      .s0_err       (s0_err),
      .s1_req       (s1_req),
      .s1_we        (s1_we),
      .s1_addr      (s1_addr),
      .s1_wdata     (s1_wdata),
      .s1_rdata     (s1_rdata),
      .s1_ack       (s1_ack),
      .s1_err       (s1_err),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_write      (m_write),
      .m_read       (m_read),
      .m_readdata   (m_readdata),
      .m_waitrequest(m_waitrequest),
      .grant        (grant),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: owner, age in cycles since grant (1 = issue cycle), done flag.
   int          md_own = -1;
   int          md_age = 0;
   int          md_last = 1;
   bit          md_we = 1'b0;
   bit          md_done = 1'b0;
   bit          md_err = 1'b0;
   logic [7:0]  md_addr = 8'd0;
   logic [31:0] md_wdata = 32'd0;
   logic [31:0] md_rdata [2] = '{32'd0, 32'd0};

   task automatic model_step();
      if (!reset_n) begin
         md_own = -1; md_age = 0; md_last = 1; md_done = 1'b0; md_err = 1'b0;
         md_rdata[0] = 32'd0; md_rdata[1] = 32'd0;
      end else if (md_own < 0) begin
         if (s0_req || s1_req) begin
            md_own   = (s0_req && s1_req) ? 1 - md_last : (s1_req ? 1 : 0);
            md_last  = md_own;
            md_age   = 1;
            md_done  = 1'b0;
            md_err   = 1'b0;
            md_we    = (md_own == 1) ? s1_we : s0_we;
            md_addr  = (md_own == 1) ? s1_addr : s0_addr;
            md_wdata = (md_own == 1) ? s1_wdata : s0_wdata;
         end
      end else if (md_done) begin
         md_own = -1; md_done = 1'b0; md_err = 1'b0;
      end else begin
         if (md_age >= H + 1 && (!m_waitrequest || md_age == H + 1 + T)) begin
            md_done = 1'b1;
            md_err  = m_waitrequest;
            if (!md_we && !m_waitrequest) md_rdata[md_own] = m_readdata;
         end
         md_age++;
      end
   endtask

   task automatic compare();
      logic [1:0] eg;
      eg = (md_own == 0) ? 2'b01 : (md_own == 1) ? 2'b10 : 2'b00;
      chk("grant", {30'd0, grant}, {30'd0, eg});
      chk("busy", {31'd0, busy}, {31'd0, md_own >= 0});
      chk("m_read", {31'd0, m_read}, {31'd0, md_own >= 0 && md_age == 1 && !md_done && !md_we});
      chk("m_write", {31'd0, m_write}, {31'd0, md_own >= 0 && md_age == 1 && !md_done && md_we});
      if (md_own >= 0) begin
         chk("m_addr", {24'd0, m_addr}, {24'd0, md_addr});
         chk("m_wdata", m_wdata, md_wdata);
      end
      chk("s0_ack", {31'd0, s0_ack}, {31'd0, md_done && md_own == 0});
      chk("s1_ack", {31'd0, s1_ack}, {31'd0, md_done && md_own == 1});
      chk("s0_err", {31'd0, s0_err}, {31'd0, md_done && md_own == 0 && md_err});
      chk("s1_err", {31'd0, s1_err}, {31'd0, md_done && md_own == 1 && md_err});
      chk("s0_rdata", s0_rdata, md_rdata[0]);
      chk("s1_rdata", s1_rdata, md_rdata[1]);
   endtask

   initial forever begin
      @(posedge clk_50 or negedge reset_n);
      model_step();
   end

   initial forever begin
      @(negedge clk_50);
      if (reset_n) compare();
   end

   task automatic set_port(input int p, input bit req, input bit we, input logic [7:0] a,
                           input logic [31:0] d);
      if (p == 0) begin
         s0_req = req; s0_we = we; s0_addr = a; s0_wdata = d;
      end else begin
         s1_req = req; s1_we = we; s1_addr = a; s1_wdata = d;
      end
   endtask

   // One request; waitrequest high during cycles wr_from..wr_to (cycle 1 = issue cycle).
   task automatic run_txn(input int p, input bit we, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] rd_base, input bit ramp, input int wr_from,
                          input int wr_to, output int lat, output int rdp, output int wrp,
                          output int stable, output logic err, output logic [31:0] rd,
                          output logic [1:0] g);
      int cyc;
      set_port(p, 1'b1, we, a, d);
      lat = -1; rdp = 0; wrp = 0; stable = 0; cyc = 0; err = 1'b0; rd = 32'd0; g = 2'b00;
      m_readdata    = rd_base;
      m_waitrequest = 1'b0;
      @(posedge clk_50);
      while (cyc < 300 && lat < 0) begin
         @(negedge clk_50);
         cyc++;
         if (cyc == 1) g = grant;
         rdp += int'(m_read);
         wrp += int'(m_write);
         if (busy && m_addr == a && m_wdata == d && !s0_ack && !s1_ack) stable++;
         if ((p == 0) ? s0_ack : s1_ack) begin
            lat = cyc;
            err = (p == 0) ? s0_err : s1_err;
            rd  = (p == 0) ? s0_rdata : s1_rdata;
         end
         m_waitrequest = (cyc >= wr_from && cyc <= wr_to);
         m_readdata    = rd_base + (ramp ? 32'(cyc) : 32'd0);
      end
      @(posedge clk_50);
      #1;
      set_port(p, 1'b0, 1'b0, 8'd0, 32'd0);
      m_waitrequest = 1'b0;
   endtask

   int          lat, rdp, wrp, stable, cyc, ng, nack, mode;
   logic        err, a0, a1, r, ak;
   logic [31:0] rd;
   logic [1:0]  g, prevg;
   logic [1:0]  seq [4];

   initial begin
      // Reset state
      repeat (3) @(posedge clk_50);
      #1;
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_m_addr", {24'd0, m_addr}, 32'd0);
      chk("rst_s0_rdata", s0_rdata, 32'd0);
      reset_n = 1'b1;
      @(posedge clk_50);
      #1;

      // Single read
      run_txn(0, 1'b0, 8'h05, 32'd0, 32'hDEADBEEF, 1'b0, 999, 0, lat, rdp, wrp, stable, err, rd, g);
      chk("read_latency", 32'(lat), 32'd12);
      chk("read_m_read_pulses", 32'(rdp), 32'd1);
      chk("read_m_write_pulses", 32'(wrp), 32'd0);
      chk("read_rdata", rd, 32'hDEADBEEF);
      chk("read_err", {31'd0, err}, 32'd0);
      chk("read_grant", {30'd0, g}, 32'd1);

      // Single write
      run_txn(1, 1'b1, 8'hFF, 32'h12345678, 32'hCAFEF00D, 1'b0, 999, 0, lat, rdp, wrp, stable,
              err, rd, g);
      chk("write_latency", 32'(lat), 32'd12);
      chk("write_m_write_pulses", 32'(wrp), 32'd1);
      chk("write_m_read_pulses", 32'(rdp), 32'd0);
      chk("write_stable_cycles", 32'(stable), 32'd11);
      chk("write_rdata_unchanged", rd, 32'd0);
      chk("write_err", {31'd0, err}, 32'd0);

      // Stall: waitrequest high on the last hold cycle plus 4 wait cycles
      run_txn(0, 1'b0, 8'h21, 32'd0, 32'hA0000000, 1'b1, H + 1, H + 5, lat, rdp, wrp, stable,
              err, rd, g);
      chk("stall_latency", 32'(lat), 32'd17);
      chk("stall_rdata", rd, 32'hA0000010);
      chk("stall_err", {31'd0, err}, 32'd0);

      // Timeout: waitrequest stuck high
      run_txn(0, 1'b0, 8'h22, 32'd0, 32'h55555555, 1'b0, 1, 9999, lat, rdp, wrp, stable, err, rd,
              g);
      chk("timeout_latency", 32'(lat), 32'd76);
      chk("timeout_err", {31'd0, err}, 32'd1);
      chk("timeout_rdata_unchanged", rd, 32'hA0000010);

      // Normal completion after a timeout
      run_txn(1, 1'b0, 8'h10, 32'd0, 32'h0BADF00D, 1'b0, 999, 0, lat, rdp, wrp, stable, err, rd,
              g);
      chk("post_timeout_latency", 32'(lat), 32'd12);
      chk("post_timeout_rdata", rd, 32'h0BADF00D);
      chk("post_timeout_err", {31'd0, err}, 32'd0);

      // Contention with both requests held continuously: grants must alternate
      set_port(0, 1'b1, 1'b0, 8'h40, 32'h0);
      set_port(1, 1'b1, 1'b1, 8'h41, 32'h77777777);
      m_waitrequest = 1'b0;
      m_readdata    = 32'h13579BDF;
      ng = 0; nack = 0; cyc = 0; prevg = 2'b00;
      for (int i = 0; i < 4; i++) seq[i] = 2'b00;
      while (nack < 4 && cyc < 400) begin
         @(negedge clk_50);
         cyc++;
         if (grant != 2'b00 && prevg == 2'b00 && ng < 4) begin
            seq[ng] = grant;
            ng++;
         end
         if (s0_ack || s1_ack) nack++;
         prevg = grant;
      end
      @(posedge clk_50);
      #1;
      set_port(0, 1'b0, 1'b0, 8'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 8'd0, 32'd0);
      chk("rr_grant0", {30'd0, seq[0]}, 32'd1);
      chk("rr_grant1", {30'd0, seq[1]}, 32'd2);
      chk("rr_grant2", {30'd0, seq[2]}, 32'd1);
      chk("rr_grant3", {30'd0, seq[3]}, 32'd2);
      chk("rr_ack_count", 32'(nack), 32'd4);

      // Reset in the middle of the hold window
      set_port(0, 1'b1, 1'b0, 8'h33, 32'h0);
      @(posedge clk_50);
      repeat (5) @(negedge clk_50);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_grant", {30'd0, grant}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_m_read", {31'd0, m_read}, 32'd0);
      chk("midrst_m_addr", {24'd0, m_addr}, 32'd0);
      chk("midrst_m_wdata", m_wdata, 32'd0);
      chk("midrst_s0_ack", {31'd0, s0_ack}, 32'd0);
      chk("midrst_s0_rdata", s0_rdata, 32'd0);
      chk("midrst_s1_rdata", s1_rdata, 32'd0);
      set_port(0, 1'b0, 1'b0, 8'd0, 32'd0);
      @(posedge clk_50);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk_50);
      #1;
      run_txn(1, 1'b0, 8'h44, 32'd0, 32'h600DCAFE, 1'b0, 999, 0, lat, rdp, wrp, stable, err, rd,
              g);
      chk("postrst_grant", {30'd0, g}, 32'd2);
      chk("postrst_latency", 32'(lat), 32'd12);
      chk("postrst_rdata", rd, 32'h600DCAFE);

      // Randomized traffic in four waitrequest regimes
      for (int c = 0; c < 4000; c++) begin
         mode = c / 1000;
         @(negedge clk_50);
         a0 = s0_ack;
         a1 = s1_ack;
         @(posedge clk_50);
         #1;
         for (int p = 0; p < 2; p++) begin
            r  = (p == 0) ? s0_req : s1_req;
            ak = (p == 0) ? a0 : a1;
            if (!r || ak) begin
               if (r ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0))
                  set_port(p, 1'b1, 1'($urandom_range(1)), 8'($urandom), $urandom);
               else
                  set_port(p, 1'b0, 1'b0, 8'd0, 32'd0);
            end
         end
         m_readdata = $urandom;
         case (mode)
            0:       m_waitrequest = 1'b0;
            1:       m_waitrequest = ($urandom_range(3) == 0);
            2:       m_waitrequest = ($urandom_range(9) != 0);
            default: m_waitrequest = ((c % 200) < 150);
         endcase
      end
      set_port(0, 1'b0, 1'b0, 8'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 8'd0, 32'd0);
      m_waitrequest = 1'b0;
      repeat (100) @(posedge clk_50);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
